// File: rtl/t03_mem_request_arbiter.sv
`default_nettype none
// ============================================================================
// t03_mem_request_arbiter : fetch/load/store arbiter onto one bus-manager port
// Rev 1.0 - byte-lane steering, alignment check, busy handshake, bus timeout
// ============================================================================
module t03_mem_request_arbiter #(
   parameter logic [31:0] ADDR_OFFSET    = 32'h3300_0000,
   parameter int unsigned TIMEOUT_CYCLES = 256,
   parameter int unsigned TO_W           = 9
) (
   input  logic        clk,
   input  logic        nrst,
   input  logic        en,
   input  logic        i_request,
   input  logic [31:0] instruction_address,
   input  logic        memread,
   input  logic        memwrite,
   input  logic [31:0] data_address,
   input  logic [31:0] data_to_write,
   input  logic [1:0]  size,
   input  logic        load_unsigned,
   input  logic        busy_o,
   input  logic [31:0] cpu_dat_o,
   output logic        read_i,
   output logic        write_i,
   output logic [31:0] adr_i,
   output logic [31:0] cpu_dat_i,
   output logic [3:0]  sel_i,
   output logic [31:0] instruction,
   output logic [31:0] data_read,
   output logic        i_hit,
   output logic        d_hit,
   output logic        bus_err
);

   typedef enum logic [1:0] {
      IDLE      = 2'd0,
      WAIT_BUSY = 2'd1,
      WAIT_DONE = 2'd2
   } state_t;

   localparam logic [1:0]      c_kind_fetch = 2'd0;
   localparam logic [1:0]      c_kind_load  = 2'd1;
   localparam logic [1:0]      c_kind_store = 2'd2;
   localparam logic [TO_W-1:0] c_timeout    = TO_W'(TIMEOUT_CYCLES);

   state_t          state_q, state_d;
   logic [TO_W-1:0] cnt_q, cnt_d;
   logic            saw_busy_q, saw_busy_d;
   logic            read_q, read_d, write_q, write_d;
   logic [31:0]     adr_q, adr_d, dat_q, dat_d;
   logic [3:0]      sel_q, sel_d;
   logic [31:0]     instr_q, instr_d, dread_q, dread_d;
   logic            i_hit_q, i_hit_d, d_hit_q, d_hit_d, err_q, err_d;
   logic [1:0]      kind_q, kind_d, size_q, size_d, off_q, off_d;
   logic            uns_q, uns_d;

   logic [1:0]      w_size_eff;
   logic            w_data_misaligned;
   logic [3:0]      w_data_sel;
   logic [31:0]     w_data_wdat;
   logic [TO_W-1:0] w_cnt_inc;
   logic            w_timeout;
   logic [31:0]     w_lane;
   logic [31:0]     w_load_val;
   logic            w_finish, w_fail;

   assign w_size_eff = (size == 2'd3) ? 2'd2 : size;
   assign w_cnt_inc  = cnt_q + TO_W'(1);
   assign w_timeout  = (TIMEOUT_CYCLES != 0) && (w_cnt_inc == c_timeout);
   assign w_lane     = cpu_dat_o >> {off_q, 3'b000};

   always_comb begin
      w_data_misaligned = 1'b0;
      w_data_sel        = 4'b1111;
      w_data_wdat       = data_to_write;
      case (w_size_eff)
         2'd0: begin
            w_data_sel  = 4'b0001 << data_address[1:0];
            w_data_wdat = {4{data_to_write[7:0]}};
         end
         2'd1: begin
            w_data_misaligned = data_address[0];
            w_data_sel        = 4'b0011 << data_address[1:0];
            w_data_wdat       = {2{data_to_write[15:0]}};
         end
         default: w_data_misaligned = |data_address[1:0];
      endcase
   end

   always_comb begin
      w_load_val = w_lane;
      case (size_q)
         2'd0: w_load_val = uns_q ? {24'd0, w_lane[7:0]} : {{24{w_lane[7]}}, w_lane[7:0]};
         2'd1: w_load_val = uns_q ? {16'd0, w_lane[15:0]} : {{16{w_lane[15]}}, w_lane[15:0]};
         default: w_load_val = w_lane;
      endcase
   end

   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      saw_busy_d = saw_busy_q;
      read_d     = 1'b0;
      write_d    = 1'b0;
      adr_d      = adr_q;
      dat_d      = dat_q;
      sel_d      = sel_q;
      instr_d    = instr_q;
      dread_d    = dread_q;
      i_hit_d    = 1'b0;
      d_hit_d    = 1'b0;
      err_d      = 1'b0;
      kind_d     = kind_q;
      size_d     = size_q;
      uns_d      = uns_q;
      off_d      = off_q;
      w_finish   = 1'b0;
      w_fail     = 1'b0;

      case (state_q)
         IDLE: begin
            // No issue at all in a hit cycle: the CPU has not yet dropped the request it just saw finish.
            if (!d_hit_q && !i_hit_q) begin
               if (memwrite || memread) begin
                  if (w_data_misaligned) begin
                     d_hit_d = 1'b1;
                     err_d   = 1'b1;
                  end else begin
                     write_d    = memwrite;
                     read_d     = !memwrite;
                     adr_d      = {data_address[31:2], 2'b00} + ADDR_OFFSET;
                     sel_d      = w_data_sel;
                     dat_d      = memwrite ? w_data_wdat : 32'd0;
                     kind_d     = memwrite ? c_kind_store : c_kind_load;
                     size_d     = w_size_eff;
                     uns_d      = load_unsigned;
                     off_d      = data_address[1:0];
                     cnt_d      = '0;
                     saw_busy_d = 1'b0;
                     state_d    = WAIT_BUSY;
                  end
               end else if (i_request) begin
                  if (|instruction_address[1:0]) begin
                     i_hit_d = 1'b1;
                     err_d   = 1'b1;
                  end else begin
                     read_d     = 1'b1;
                     adr_d      = {instruction_address[31:2], 2'b00} + ADDR_OFFSET;
                     sel_d      = 4'b1111;
                     dat_d      = 32'd0;
                     kind_d     = c_kind_fetch;
                     size_d     = 2'd2;
                     uns_d      = 1'b0;
                     off_d      = 2'd0;
                     cnt_d      = '0;
                     saw_busy_d = 1'b0;
                     state_d    = WAIT_BUSY;
                  end
               end
            end
         end
         WAIT_BUSY: begin
            cnt_d = w_cnt_inc;
            if (w_timeout) begin
               w_finish = 1'b1;
               w_fail   = 1'b1;
            end else if (busy_o) begin
               saw_busy_d = 1'b1;
               state_d    = WAIT_DONE;
            end
         end
         WAIT_DONE: begin
            cnt_d = w_cnt_inc;
            // Completion takes precedence over a timeout landing on the same cycle.
            if (!busy_o && saw_busy_q) begin
               w_finish = 1'b1;
            end else if (w_timeout) begin
               w_finish = 1'b1;
               w_fail   = 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase

      if (w_finish) begin
         state_d    = IDLE;
         saw_busy_d = 1'b0;
         adr_d      = 32'd0;
         sel_d      = 4'd0;
         dat_d      = 32'd0;
         err_d      = w_fail;
         if (kind_q == c_kind_fetch) begin
            i_hit_d = 1'b1;
            if (!w_fail) instr_d = cpu_dat_o;
         end else begin
            d_hit_d = 1'b1;
            if (!w_fail && kind_q == c_kind_load) dread_d = w_load_val;
         end
      end
   end

   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) begin
         state_q    <= IDLE;
         cnt_q      <= '0;
         saw_busy_q <= 1'b0;
         read_q     <= 1'b0;
         write_q    <= 1'b0;
         adr_q      <= 32'd0;
         dat_q      <= 32'd0;
         sel_q      <= 4'd0;
         instr_q    <= 32'd0;
         dread_q    <= 32'd0;
         i_hit_q    <= 1'b0;
         d_hit_q    <= 1'b0;
         err_q      <= 1'b0;
         kind_q     <= c_kind_fetch;
         size_q     <= 2'd0;
         uns_q      <= 1'b0;
         off_q      <= 2'd0;
      end else if (en) begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         saw_busy_q <= saw_busy_d;
         read_q     <= read_d;
         write_q    <= write_d;
         adr_q      <= adr_d;
         dat_q      <= dat_d;
         sel_q      <= sel_d;
         instr_q    <= instr_d;
         dread_q    <= dread_d;
         i_hit_q    <= i_hit_d;
         d_hit_q    <= d_hit_d;
         err_q      <= err_d;
         kind_q     <= kind_d;
         size_q     <= size_d;
         uns_q      <= uns_d;
         off_q      <= off_d;
      end
   end

   assign read_i      = read_q;
   assign write_i     = write_q;
   assign adr_i       = adr_q;
   assign cpu_dat_i   = dat_q;
   assign sel_i       = sel_q;
   assign instruction = instr_q;
   assign data_read   = dread_q;
   assign i_hit       = i_hit_q;
   assign d_hit       = d_hit_q;
   assign bus_err     = err_q;

endmodule
`default_nettype wire

// File: tb/tb_t03_mem_request_arbiter.sv
`default_nettype none
// ============================================================================
// tb_t03_mem_request_arbiter : directed bench for t03_mem_request_arbiter
// Rev 1.0
// ============================================================================
module tb_t03_mem_request_arbiter;

   logic        clk = 1'b0;
   logic        nrst = 1'b0;
   logic        en = 1'b1;
   logic        i_request = 1'b0;
   logic [31:0] instruction_address = 32'd0;
   logic        memread = 1'b0;
   logic        memwrite = 1'b0;
   logic [31:0] data_address = 32'd0;
   logic [31:0] data_to_write = 32'd0;
   logic [1:0]  size = 2'd2;
   logic        load_unsigned = 1'b0;
   logic        busy_o = 1'b0;
   logic [31:0] cpu_dat_o = 32'd0;
   logic        read_i, write_i, i_hit, d_hit, bus_err;
   logic [31:0] adr_i, cpu_dat_i, instruction, data_read;
   logic [3:0]  sel_i;

   int n_tests = 0;
   int n_fail  = 0;

   always #5 clk = ~clk;

   t03_mem_request_arbiter #(
      .ADDR_OFFSET    (32'h3300_0000),
      .TIMEOUT_CYCLES (4),
      .TO_W           (4)
   ) dut (
      .clk                 (clk),
      .nrst                (nrst),
      .en                  (en),
      .i_request           (i_request),
      .instruction_address (instruction_address),
      .memread             (memread),
      .memwrite            (memwrite),
      .data_address        (data_address),
      .data_to_write       (data_to_write),
      .size                (size),
      .load_unsigned       (load_unsigned),
      .busy_o              (busy_o),
      .cpu_dat_o           (cpu_dat_o),
      .read_i              (read_i),
      .write_i             (write_i),
      .adr_i               (adr_i),
      .cpu_dat_i           (cpu_dat_i),
      .sel_i               (sel_i),
      .instruction         (instruction),
      .data_read           (data_read),
      .i_hit               (i_hit),
      .d_hit               (d_hit),
      .bus_err             (bus_err)
   );

   task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Bus manager: busy high for nbusy cycles, then low; returns one step after busy falls.
   task automatic bus_xact(input int nbusy, input logic [31:0] rdata);
      busy_o    = 1'b1;
      cpu_dat_o = rdata;
      repeat (nbusy) step();
      busy_o = 1'b0;
      step();
   endtask

   initial begin
      // Reset
      repeat (2) @(posedge clk);
      #1;
      check("rst_read", {31'd0, read_i}, 32'd0);
      check("rst_adr", adr_i, 32'd0);
      check("rst_hits", {29'd0, i_hit, d_hit, bus_err}, 32'd0);
      @(negedge clk);
      nrst = 1'b1;
      step();

      // Fetch
      i_request = 1'b1;
      instruction_address = 32'h100;
      step();
      check("f_read", {31'd0, read_i}, 32'd1);
      check("f_adr", adr_i, 32'h3300_0100);
      check("f_sel", {28'd0, sel_i}, 32'hF);
      busy_o = 1'b1;
      cpu_dat_o = 32'h00A0_0093;
      step();
      check("f_read_pulse", {31'd0, read_i}, 32'd0);
      check("f_adr_hold", adr_i, 32'h3300_0100);
      check("f_no_early_hit", {31'd0, i_hit}, 32'd0);
      step();
      step();
      busy_o = 1'b0;
      step();
      check("f_ihit", {30'd0, i_hit, bus_err}, 32'd2);
      check("f_instr", instruction, 32'h00A0_0093);
      check("f_adr_clr", adr_i, 32'd0);
      i_request = 1'b0;
      step();
      check("f_ihit_pulse", {31'd0, i_hit}, 32'd0);

      // Priority: store, then load, then fetch
      memwrite = 1'b1;
      memread = 1'b1;
      i_request = 1'b1;
      size = 2'd2;
      data_address = 32'h10;
      data_to_write = 32'hDEAD_BEEF;
      step();
      check("p_write", {30'd0, write_i, read_i}, 32'd2);
      check("p_wdat", cpu_dat_i, 32'hDEAD_BEEF);
      check("p_wadr", adr_i, 32'h3300_0010);
      bus_xact(1, 32'd0);
      check("p_st_hit", {30'd0, d_hit, i_hit}, 32'd2);
      memwrite = 1'b0;
      step();
      check("p_no_reissue", {30'd0, read_i, write_i}, 32'd0);
      step();
      check("p_load_next", {30'd0, read_i, write_i}, 32'd2);
      check("p_ladr", adr_i, 32'h3300_0010);
      check("p_ldat", cpu_dat_i, 32'd0);
      bus_xact(1, 32'h1122_3344);
      check("p_ld_hit", {31'd0, d_hit}, 32'd1);
      check("p_ld_val", data_read, 32'h1122_3344);
      memread = 1'b0;
      step();
      check("p_no_reissue2", {31'd0, read_i}, 32'd0);
      step();
      check("p_fetch_last", {31'd0, read_i}, 32'd1);
      check("p_fadr", adr_i, 32'h3300_0100);
      bus_xact(2, 32'hCAFE_F00D);
      check("p_f_hit", {30'd0, i_hit, d_hit}, 32'd2);
      check("p_instr", instruction, 32'hCAFE_F00D);
      i_request = 1'b0;
      step();

      // Sub-word loads, signed then unsigned
      memread = 1'b1;
      size = 2'd0;
      load_unsigned = 1'b0;
      data_address = 32'h203;
      step();
      check("lb_adr", adr_i, 32'h3300_0200);
      check("lb_sel", {28'd0, sel_i}, 32'h8);
      bus_xact(1, 32'h80FF_0000);
      check("lb_signed", data_read, 32'hFFFF_FF80);
      memread = 1'b0;
      step();
      memread = 1'b1;
      load_unsigned = 1'b1;
      step();
      check("lbu_read", {31'd0, read_i}, 32'd1);
      bus_xact(1, 32'h80FF_0000);
      check("lbu_val", data_read, 32'h0000_0080);
      memread = 1'b0;
      step();

      // Half store
      memwrite = 1'b1;
      size = 2'd1;
      data_address = 32'h42;
      data_to_write = 32'h1234_ABCD;
      step();
      check("sh_sel", {28'd0, sel_i}, 32'hC);
      check("sh_dat", cpu_dat_i, 32'hABCD_ABCD);
      check("sh_adr", adr_i, 32'h3300_0040);
      bus_xact(2, 32'd0);
      check("sh_hit", {31'd0, d_hit}, 32'd1);
      check("sh_clr", {cpu_dat_i[27:0], sel_i}, 32'd0);
      memwrite = 1'b0;
      step();

      // Misaligned word load
      memread = 1'b1;
      size = 2'd2;
      data_address = 32'h41;
      step();
      check("mis_nostrobe", {30'd0, read_i, write_i}, 32'd0);
      check("mis_hit_err", {30'd0, d_hit, bus_err}, 32'd3);
      check("mis_keep", data_read, 32'h0000_0080);
      memread = 1'b0;
      step();
      check("mis_pulse", {30'd0, d_hit, bus_err}, 32'd0);

      // Misaligned fetch
      i_request = 1'b1;
      instruction_address = 32'h102;
      step();
      check("fmis_hit_err", {29'd0, i_hit, bus_err, read_i}, 32'd6);
      check("fmis_keep", instruction, 32'hCAFE_F00D);
      i_request = 1'b0;
      instruction_address = 32'h100;
      step();

      // Timeout with busy stuck low
      memread = 1'b1;
      data_address = 32'h80;
      step();
      check("to_read", {31'd0, read_i}, 32'd1);
      repeat (3) step();
      check("to_not_yet", {31'd0, d_hit}, 32'd0);
      step();
      check("to_hit_err", {30'd0, d_hit, bus_err}, 32'd3);
      check("to_keep", data_read, 32'h0000_0080);
      check("to_adr_clr", adr_i, 32'd0);
      memread = 1'b0;
      step();

      // Enable freeze in WAIT_DONE
      memread = 1'b1;
      data_address = 32'h84;
      step();
      busy_o = 1'b1;
      cpu_dat_o = 32'h55AA_55AA;
      step();
      step();
      en = 1'b0;
      busy_o = 1'b0;
      repeat (5) step();
      check("en_no_hit", {30'd0, d_hit, bus_err}, 32'd0);
      check("en_adr_hold", adr_i, 32'h3300_0084);
      en = 1'b1;
      busy_o = 1'b1;
      step();
      check("en_no_timeout", {31'd0, d_hit}, 32'd0);
      busy_o = 1'b0;
      step();
      check("en_done", {30'd0, d_hit, bus_err}, 32'd2);
      check("en_val", data_read, 32'h55AA_55AA);
      memread = 1'b0;
      en = 1'b0;
      step();
      check("en_hit_frozen", {31'd0, d_hit}, 32'd1);
      en = 1'b1;
      step();
      check("en_hit_clear", {31'd0, d_hit}, 32'd0);

      // Reset mid-transaction
      i_request = 1'b1;
      instruction_address = 32'h200;
      step();
      check("rm_read", {31'd0, read_i}, 32'd1);
      busy_o = 1'b1;
      step();
      #2;
      nrst = 1'b0;
      #1;
      check("rm_async_adr", adr_i, 32'd0);
      check("rm_async_sel", {28'd0, sel_i}, 32'd0);
      i_request = 1'b0;
      busy_o = 1'b0;
      @(posedge clk);
      @(negedge clk);
      nrst = 1'b1;
      step();
      step();
      check("rm_no_hit", {29'd0, i_hit, d_hit, read_i}, 32'd0);
      check("rm_instr", instruction, 32'd0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
